// File: rtl/muldiv_unit.sv
// Iterative HI/LO unit: 32-step shift-add multiply and restoring divide.
// Owns the HI/LO registers and holds the pipeline until a result commits.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  input  logic              flush,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state;
  logic [CNT_W-1:0]    counter;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   b_reg;
  logic [DATA_W-1:0]   orig_op1;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;

  // Operation decode and operand conditioning
  logic              multi_op;
  logic              signed_op;
  logic              div_op;
  logic              op1_neg;
  logic              op2_neg;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic              start;

  assign multi_op  = (funct == F_MULT) || (funct == F_MULTU) ||
                     (funct == F_DIV)  || (funct == F_DIVU);
  assign signed_op = (funct == F_MULT) || (funct == F_DIV);
  assign div_op    = (funct == F_DIV)  || (funct == F_DIVU);
  assign op1_neg   = signed_op & operand_1[DATA_W-1];
  assign op2_neg   = signed_op & operand_2[DATA_W-1];
  assign mag1      = op1_neg ? -operand_1 : operand_1;
  assign mag2      = op2_neg ? -operand_2 : operand_2;
  assign start     = (state == IDLE) & en & multi_op & ~done & ~flush;

  assign stall_req = (state != IDLE) | (en & multi_op & ~done);

  // One iteration step. Multiply keeps {partial product, multiplier} in acc and
  // shifts right; divide keeps {remainder, dividend/quotient} and shifts left.
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_trial;
  logic                div_ge;
  logic [DATA_W-1:0]   div_diff;
  logic [2*DATA_W-1:0] acc_step;

  assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_reg} : '0);
  assign div_trial = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_ge    = div_trial >= {1'b0, b_reg};
  assign div_diff  = div_trial[DATA_W-1:0] - b_reg;
  assign acc_step  = !is_div ? {mul_sum, acc[DATA_W-1:1]} :
                     div_ge  ? {div_diff, acc[DATA_W-2:0], 1'b1} :
                               {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};

  // Sign fix-up applied when the result is committed
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem_fix  = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      acc      <= '0;
      b_reg    <= '0;
      orig_op1 <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state    <= RUN;
              counter  <= '0;
              acc      <= {{DATA_W{1'b0}}, div_op ? mag1 : mag2};
              b_reg    <= div_op ? mag2 : mag1;
              orig_op1 <= operand_1;
              is_div   <= div_op;
              neg_q    <= op1_neg ^ op2_neg;
              neg_r    <= op1_neg;
            end else if (en && funct == F_MTHI) begin
              hi <= operand_1;
            end else if (en && funct == F_MTLO) begin
              lo <= operand_1;
            end
          end
          RUN: begin
            acc     <= acc_step;
            counter <= counter + 1'b1;
            if (counter == CNT_W'(DATA_W - 1)) state <= FIX;
          end
          FIX: begin
            state <= IDLE;
            done  <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (b_reg == '0) begin
              lo <= '1;
              hi <= orig_op1;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
